// File: rtl/ecc_pkg.sv
// Hamming code helpers: parity-bit count, power-of-two test, data-bit placement.
// Latency: none (elaboration-time functions only).
// Backpressure: not applicable.
package ecc_pkg;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    // Smallest P with 2^P >= data_width + P + 1.
    function automatic int par_width(input int data_width);
        int p;
        p = 1;
        while ((1 << p) < data_width + p + 1) p++;
        return p;
    endfunction

    // Hamming position (1-based) holding data bit idx: the idx-th non-power-of-two position.
    function automatic int data_pos(input int idx);
        int seen;
        int pos;
        seen = 0;
        pos  = 0;
        for (int p = 1; p < 128; p++) begin
            if (!is_pow2(p)) begin
                if (seen == idx && pos == 0) pos = p;
                seen++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Places data bits at non-power-of-two Hamming positions and fills even parity at 2^k.
// Latency: combinational.
// Backpressure: none; driven by the S1 register of the encoder pipeline.
module hamming_parity_gen
    import ecc_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    localparam int PAR_WIDTH  = par_width(DATA_WIDTH),
    localparam int HAM_WIDTH  = DATA_WIDTH + PAR_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic [HAM_WIDTH-1:0]  hamming
);

    logic par;

    // Codeword bit i carries Hamming position i+1.
    always_comb begin
        hamming = '0;
        par     = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            hamming[data_pos(i) - 1] = data[i];
        end
        for (int k = 0; k < PAR_WIDTH; k++) begin
            par = 1'b0;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (((data_pos(i) >> k) & 1) != 0) par = par ^ data[i];
            end
            hamming[(1 << k) - 1] = par;
        end
    end

endmodule

// File: rtl/stream_hamming_encoder.sv
// Two-stage valid/ready Hamming encoder with saturating accepted-word counter; STREAM_ENC_SECDED_EN adds overall parity MSB.
// Latency: 2 cycles from input transfer to out_valid; one word per cycle when unstalled.
// Backpressure: stalled S2 holds codeword; S1 refills only when S2 can advance, so in_ready drops once both are full.
module stream_hamming_encoder
    import ecc_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int CNT_WIDTH  = 16,
    localparam int PAR_WIDTH  = par_width(DATA_WIDTH),
    localparam int HAM_WIDTH  = DATA_WIDTH + PAR_WIDTH,
`ifdef STREAM_ENC_SECDED_EN
    localparam int CW_WIDTH   = HAM_WIDTH + 1
`else
    localparam int CW_WIDTH   = HAM_WIDTH
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CW_WIDTH-1:0]   codeword,
    output logic [CNT_WIDTH-1:0]  word_count
);

    logic                  s1_vld;
    logic [DATA_WIDTH-1:0] s1_dat;
    logic                  s2_adv;
    logic                  in_xfer;
    logic [HAM_WIDTH-1:0]  ham;
    logic [CW_WIDTH-1:0]   cw_nxt;

    assign s2_adv   = !out_valid || out_ready;
    // Gating with rst_n keeps in_ready low for the whole reset window.
    assign in_ready = rst_n && (!s1_vld || s2_adv);
    assign in_xfer  = in_valid && in_ready;

    hamming_parity_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_gen (
        .data    (s1_dat),
        .hamming (ham)
    );

`ifdef STREAM_ENC_SECDED_EN
    assign cw_nxt = {^ham, ham};
`else
    assign cw_nxt = ham;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else if (in_xfer) begin
            s1_vld <= 1'b1;
            s1_dat <= data_in;
        end else if (s2_adv) begin
            s1_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            codeword  <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_vld;
            if (s1_vld) codeword <= cw_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count <= '0;
        end else if (in_xfer && (word_count != {CNT_WIDTH{1'b1}})) begin
            word_count <= word_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_hamming_encoder.sv
// Randomized self-checking bench: Hamming reference model, scoreboard, directed corner cases.
`timescale 1ns/1ps
module tb_stream_hamming_encoder;

    localparam int DW = 8;
    localparam int PW = 4;
    localparam int HW = DW + PW;
`ifdef STREAM_ENC_SECDED_EN
    localparam int CW = HW + 1;
    localparam logic [CW-1:0] EXP_01 = 13'h1007;
    localparam logic [CW-1:0] EXP_FF = 13'h0F77;
`else
    localparam int CW = HW;
    localparam logic [CW-1:0] EXP_01 = 12'h007;
    localparam logic [CW-1:0] EXP_FF = 12'hF77;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          b_out_ready = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          in_ready, out_valid;
    logic [CW-1:0] codeword;
    logic [15:0]   word_count;
    logic          b_in_ready, b_out_valid;
    logic [CW-1:0] b_codeword;
    logic [3:0]    b_word_count;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sb_q[$];
    int            out_cycles[$];
    int            cyc = 0;
    int            a_cnt = 0;
    int            b_cnt = 0;
    bit            prev_stall = 1'b0;
    logic [CW-1:0] prev_cw = '0;
    bit            rand_bp = 1'b0;

    always #5 clk = ~clk;

    stream_hamming_encoder #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .codeword(codeword), .word_count(word_count)
    );

    stream_hamming_encoder #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .data_in(data_in), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .codeword(b_codeword), .word_count(b_word_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Build the Hamming word position by position: data in non-power-of-two slots, then parities.
    function automatic logic [CW-1:0] ref_encode(input logic [DW-1:0] d);
        logic [HW:1]   pos_bit;
        logic [CW-1:0] cw;
        logic          par;
        int            k;
        pos_bit = '0;
        k = 0;
        for (int pos = 1; pos <= HW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                pos_bit[pos] = d[k];
                k++;
            end
        end
        for (int p = 1; p <= HW; p = p * 2) begin
            par = 1'b0;
            for (int pos = 1; pos <= HW; pos++)
                if ((pos & p) != 0 && pos != p) par = par ^ pos_bit[pos];
            pos_bit[p] = par;
        end
        cw = '0;
        cw[HW-1:0] = pos_bit;
`ifdef STREAM_ENC_SECDED_EN
        cw[CW-1] = ^pos_bit;
`endif
        return cw;
    endfunction

    // Monitor: scoreboard, hold-under-stall checks and counter models.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            sb_q.delete();
            a_cnt = 0;
            b_cnt = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_cw", codeword, prev_cw);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) check("spurious_out", sb_q.size(), 1);
                else check("codeword", codeword, ref_encode(sb_q.pop_front()));
                out_cycles.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(data_in);
                if (a_cnt < 65535) a_cnt++;
            end
            if (in_valid && b_in_ready && b_cnt < 15) b_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_cw    = codeword;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic [DW-1:0] d, output int waits);
        waits = 0;
        in_valid = 1'b1;
        data_in = d;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_codeword", codeword, 0);
        check("rst_word_count", word_count, 0);
        check("rst_sat_count", b_word_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((sb_q.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic one_word(input logic [DW-1:0] d, input logic [CW-1:0] exp, input string tag);
        int w;
        int lat;
        send(d, w);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        check({tag, "_latency"}, lat, 2);
        check({tag, "_cw"}, codeword, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int stalls;
        int acc;
        int stale;
        int base;
        bit took;

        do_reset();
        out_ready = 1'b1;

        one_word(8'h01, EXP_01, "w01");
        check("count_1", word_count, 1);
        one_word(8'hFF, EXP_FF, "wFF");
        one_word(8'h00, '0, "w00");
        check("count_3", word_count, a_cnt);

        // Full-throughput random stream.
        base = out_cycles.size();
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            send(DW'($urandom), w);
            stalls += w;
        end
        check("stream_stalls", stalls, 0);
        drain();
        check("stream_outs", out_cycles.size() - base, 16);
        if (out_cycles.size() >= base + 16)
            check("stream_spacing", out_cycles[base+15] - out_cycles[base], 15);
        check("count_stream", word_count, a_cnt);

        // Output stalled for 5 cycles with input offered every cycle.
        out_ready = 1'b0;
        in_valid = 1'b1;
        data_in = DW'($urandom);
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            took = in_ready;
            if (took) acc++;
            @(posedge clk);
            #1;
            if (took) data_in = DW'($urandom);
        end
        check("stall_accepts", acc, 2);
        check("stall_in_ready", in_ready, 0);
        in_valid = 1'b0;
        drain();

        // Random backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) send(DW'($urandom), w);
        rand_bp = 1'b0;
        drain();
        check("count_bp", word_count, a_cnt);

        // Reset with both stages full.
        out_ready = 1'b0;
        send(DW'($urandom), w);
        send(DW'($urandom), w);
        check("full_out_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        do_reset();
        out_ready = 1'b1;
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("stale_out", stale, 0);
        @(posedge clk);
        #1;

        // Counter saturation on the narrow-counter instance.
        for (int i = 0; i < 10; i++) send(DW'($urandom), w);
        drain();
        check("sat_count_10", b_word_count, b_cnt);
        for (int i = 0; i < 10; i++) send(DW'($urandom), w);
        drain();
        check("sat_count_model", b_word_count, b_cnt);
        check("sat_count_max", b_word_count, 4'hF);
        check("count_20", word_count, a_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_hamming_encoder.md
STREAM_HAMMING_ENCODER -- requirements
Module: stream_hamming_encoder

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload width; legal range 4..57.
REQ-002 Parameter CNT_WIDTH, default 16, width of the accepted-word counter.
REQ-003 Derived constant PAR_WIDTH: smallest P with 2^P >= DATA_WIDTH+P+1 (4 for DATA_WIDTH=8).
REQ-004 Derived constant CW_WIDTH: DATA_WIDTH+PAR_WIDTH, plus 1 when STREAM_ENC_SECDED_EN is defined.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  data_in holds a word to encode.
REQ-008 in_ready  output  1  block accepts data_in this cycle.
REQ-009 data_in  input  DATA_WIDTH  payload.
REQ-010 out_valid  output  1  codeword holds an encoded word.
REQ-011 out_ready  input  1  downstream accepts codeword this cycle.
REQ-012 codeword  output  CW_WIDTH  encoded word.
REQ-013 word_count  output  CNT_WIDTH  number of accepted input words.

Function
REQ-014 Transfer occurs on a cycle where valid and ready are both high; out_valid and codeword SHALL not change while out_valid=1 and out_ready=0.
REQ-015 Two-stage pipeline: S1 registers data_in; S2 registers the computed codeword; latency from input transfer to out_valid SHALL be exactly 2 cycles when unstalled.
REQ-016 in_ready SHALL equal !S1.valid || (!S2.valid || out_ready) (combinational, no dependency on in_valid).
REQ-017 Full throughput: with in_valid and out_ready held high, one transfer per cycle on both ports.
REQ-018 Under stall, both stages fill and in_ready drops; no word lost or duplicated; order preserved.
REQ-019 Codeword layout: Hamming positions 1..DATA_WIDTH+PAR_WIDTH map to codeword bits [0..]; power-of-two positions hold parity, remaining positions hold data_in bits LSB first.
REQ-020 Parity at position 2^k SHALL be even parity (XOR) of all data positions whose index has bit k set.
REQ-021 word_count SHALL increment by 1 per input transfer, saturating at all-ones (no wrap).
REQ-022 Simultaneous S2 drain and S1 refill in one cycle SHALL be handled with no bubble.

Reset
REQ-023 While rst_n=0: in_ready=0, out_valid=0, codeword=0, word_count=0, both stage valids cleared.
REQ-024 Reset mid-stream SHALL discard in-flight words; first cycle after release in_ready=1.

Configuration
REQ-025 Macro STREAM_ENC_SECDED_EN defined: codeword MSB = XOR of all lower codeword bits (overall parity, SEC-DED); undefined: no extra bit, plain Hamming SEC.

Structure
REQ-026 Package ecc_pkg SHALL hold the PAR_WIDTH computation function and the is-power-of-two helper.
REQ-027 Combinational sub-module hamming_parity_gen (data in, parity-placed codeword out), instantiated between S1 and S2.

Verification
REQ-028 Reset release, data_in=8'h01 single transfer -> out_valid 2 cycles later, codeword=12'h007 (13'h1007 with SECDED), word_count=1.
REQ-029 data_in=8'hFF -> codeword=12'hF77 (13'h0F77 with SECDED); data_in=8'h00 -> all-zero codeword.
REQ-030 Stream 16 random words, out_ready=1 -> 16 outputs on consecutive cycles, matching reference model, in order.
REQ-031 out_ready=0 for 5 cycles mid-stream -> in_ready low after 2 accepts, codeword stable, all words later delivered in order.
REQ-032 Assert rst_n=0 with both stages full -> out_valid=0, word_count=0 immediately; no stale word after release.
REQ-033 CNT_WIDTH=4, 20 transfers -> word_count saturates at 4'hF.
